// File: rtl/logic_seq_pkg.sv
// logic_seq_pkg: opcodes, FSM state encoding and unit enable indices for the logic op sequencer
package logic_seq_pkg;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam int EN_AND = 0;
  localparam int EN_OR  = 1;
  localparam int EN_XOR = 2;
  localparam int EN_NOT = 3;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
  function automatic logic [3:0] op_onehot(input logic [2:0] op);
    return op[2] ? 4'b0000 : 4'b0001 << op[1:0];
  endfunction
endpackage

// File: rtl/AND_D.sv
// AND_D: 4-bit AND unit, output forced to zero when not enabled
module AND_D (
  input  logic       en,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] y
);
  assign y = en ? a & b : 4'h0;
endmodule

// File: rtl/NOT_D.sv
// NOT_D: 8-bit inverter unit, output forced to zero when not enabled
module NOT_D (
  input  logic       en,
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = en ? ~a : 8'h00;
endmodule

// File: rtl/OR_D.sv
// OR_D: 4-bit OR unit, output forced to zero when not enabled
module OR_D (
  input  logic       en,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] y
);
  assign y = en ? a | b : 4'h0;
endmodule

// File: rtl/XOR_D.sv
// XOR_D: 4-bit XOR unit, output forced to zero when not enabled
module XOR_D (
  input  logic       en,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] y
);
  assign y = en ? a ^ b : 4'h0;
endmodule

// File: rtl/logic_unit_bank.sv
// logic_unit_bank: the four logic units plus the result mux selected by the latched opcode
module logic_unit_bank
  import logic_seq_pkg::*;
(
  input  logic [2:0] op,
  input  logic [7:0] a,
  input  logic [3:0] b,
  input  logic [3:0] unit_en,
  output logic [7:0] result,
  output logic       illegal
);
  logic [3:0] y_and, y_or, y_xor;
  logic [7:0] y_not;
  AND_D u_and (.en(unit_en[EN_AND]), .a(a[3:0]), .b(b), .y(y_and));
  OR_D  u_or  (.en(unit_en[EN_OR]),  .a(a[3:0]), .b(b), .y(y_or));
  XOR_D u_xor (.en(unit_en[EN_XOR]), .a(a[3:0]), .b(b), .y(y_xor));
  NOT_D u_not (.en(unit_en[EN_NOT]), .a(a),      .y(y_not));
  always_comb begin
    result  = op == OP_AND ? {4'h0, y_and} :
              op == OP_OR  ? {4'h0, y_or}  :
              op == OP_XOR ? {4'h0, y_xor} :
              op == OP_NOT ? y_not : 8'h00;
    illegal = op[2];
  end
endmodule

// File: rtl/logic_op_sequencer.sv
// logic_op_sequencer: accepts one logic command, pulses one unit enable, holds the result until consumed
module logic_op_sequencer
  import logic_seq_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic             res_err,
  output logic [3:0]       unit_en,
  output logic [CNT_W-1:0] op_count,
  output logic             busy
);
  state_t     state, state_d;
  logic [2:0] op_q;
  logic [7:0] a_q, result;
  logic [3:0] b_q;
  logic       illegal;
  assign cmd_ready = state == IDLE;
  always_comb begin
    state_d = state == IDLE ? (cmd_valid ? EXEC : IDLE) :
              state == EXEC ? RESP :
              (res_ready ? IDLE : RESP);
  end
  // enables are computed from the incoming opcode so they are a clean flop output during EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= 3'b000;
      a_q       <= 8'h00;
      b_q       <= 4'h0;
      res_valid <= 1'b0;
      res_data  <= 8'h00;
      res_err   <= 1'b0;
      unit_en   <= 4'b0000;
      op_count  <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      busy      <= state_d != IDLE;
      res_valid <= state_d == RESP;
      unit_en   <= state_d == EXEC ? op_onehot(cmd_op) : 4'b0000;
      if (state == IDLE && cmd_valid) begin
        op_q <= cmd_op;
        a_q  <= cmd_a;
        b_q  <= cmd_b;
      end
      if (state == EXEC) begin
        res_data <= result;
        res_err  <= illegal;
      end
      if (state == RESP && res_ready) op_count <= op_count + 1'b1;
    end
  end
  logic_unit_bank u_bank (
    .op(op_q), .a(a_q), .b(b_q), .unit_en(unit_en), .result(result), .illegal(illegal)
  );
endmodule

// File: tb/tb_logic_op_sequencer.sv
// tb_logic_op_sequencer: randomized and directed checks against a behavioural model, CNT_W=8 and CNT_W=2 instances
module tb_logic_op_sequencer;
  logic       clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, res_ready = 1'b0;
  logic [2:0] cmd_op = 3'b000;
  logic [7:0] cmd_a = 8'h00;
  logic [3:0] cmd_b = 4'h0;
  logic       cmd_ready, res_valid, res_err, busy;
  logic [7:0] res_data;
  logic [3:0] unit_en;
  logic [7:0] op_count;
  logic       cmd_ready2, res_valid2, res_err2, busy2;
  logic [7:0] res_data2;
  logic [3:0] unit_en2;
  logic [1:0] op_count2;
  int vectors = 0, miscompares = 0, model_cnt = 0;
  time last_acc = 0;
  bit prev_b2b = 1'b0;

  logic_op_sequencer #(.CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_err(res_err), .unit_en(unit_en), .op_count(op_count), .busy(busy)
  );
  logic_op_sequencer #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .res_valid(res_valid2), .res_ready(res_ready), .res_data(res_data2),
    .res_err(res_err2), .unit_en(unit_en2), .op_count(op_count2), .busy(busy2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_res(input logic [2:0] op, input logic [7:0] a, input logic [3:0] b);
    case (op)
      3'd0: return {4'h0, a[3:0] & b};
      3'd1: return {4'h0, a[3:0] | b};
      3'd2: return {4'h0, a[3:0] ^ b};
      3'd3: return ~a;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [3:0] ref_en(input logic [2:0] op);
    return op > 3'd3 ? 4'h0 : 4'(1 << op);
  endfunction

  task automatic check_counts(input string tag);
    check({tag, "_count"}, op_count, model_cnt % 256);
    check({tag, "_count2"}, op_count2, model_cnt % 4);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_data"}, res_data, 0);
    check({tag, "_res_err"}, res_err, 0);
    check({tag, "_unit_en"}, unit_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_res_valid2"}, res_valid2, 0);
    check_counts(tag);
  endtask

  // called at a negedge with the DUT idle; returns at the negedge after the consume edge
  task automatic run_cmd(input logic [2:0] op, input logic [7:0] a, input logic [3:0] b, input int stall);
    logic [7:0] er;
    er = ref_res(op, a, b);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    res_ready = (stall == 0);
    check("idle_cmd_ready", cmd_ready, 1);
    @(posedge clk);
    if (prev_b2b) check("accept_spacing", 32'(($time - last_acc) / 10), 3);
    last_acc = $time;
    prev_b2b = (stall == 0);
    @(negedge clk);
    cmd_valid = 1'($urandom); cmd_op = 3'($urandom); cmd_a = 8'($urandom); cmd_b = 4'($urandom);
    check("exec_unit_en", unit_en, ref_en(op));
    check("exec_busy", busy, 1);
    check("exec_cmd_ready", cmd_ready, 0);
    check("exec_res_valid", res_valid, 0);
    @(negedge clk);
    check("resp_res_valid", res_valid, 1);
    check("resp_res_data", res_data, er);
    check("resp_res_err", res_err, op[2]);
    check("resp_res_data2", res_data2, er);
    check("resp_unit_en", unit_en, 0);
    check("resp_cmd_ready", cmd_ready, 0);
    check_counts("resp");
    for (int i = 0; i < stall; i++) begin
      cmd_valid = 1'b1; cmd_op = 3'($urandom); cmd_a = 8'($urandom);
      @(negedge clk);
      check("hold_res_valid", res_valid, 1);
      check("hold_res_data", res_data, er);
      check("hold_res_err", res_err, op[2]);
      check("hold_cmd_ready", cmd_ready, 0);
      check("hold_unit_en", unit_en, 0);
      check_counts("hold");
    end
    res_ready = 1'b1;
    @(negedge clk);
    model_cnt++;
    cmd_valid = 1'b0;
    check("done_res_valid", res_valid, 0);
    check("done_cmd_ready", cmd_ready, 1);
    check("done_busy", busy, 0);
    check("done_unit_en", unit_en, 0);
    check_counts("done");
  endtask

  initial begin
    #1;
    check_reset_outputs("por");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_rst");
    run_cmd(3'b000, 8'h0C, 4'hA, 0);
    run_cmd(3'b011, 8'h5A, 4'h0, 0);
    run_cmd(3'b001, 8'h03, 4'h4, 0);
    run_cmd(3'b010, 8'h0F, 4'h5, 0);
    run_cmd(3'b010, 8'h06, 4'h3, 10);
    run_cmd(3'b101, 8'hFF, 4'hF, 1);
    // abort mid-EXEC with asynchronous reset
    cmd_valid = 1'b1; cmd_op = 3'b011; cmd_a = 8'h33; cmd_b = 4'h2; res_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("abort_exec_unit_en", unit_en, 4'b1000);
    #2 rst_n = 1'b0;
    model_cnt = 0;
    prev_b2b = 1'b0;
    #1 check_reset_outputs("abort");
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs("abort_hold");
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_cmd(3'b000, 8'h01, 4'h1, 0);
    repeat (5) run_cmd(3'($urandom_range(0, 3)), 8'($urandom), 4'($urandom), 0);
    repeat (80) run_cmd(3'($urandom), 8'($urandom), 4'($urandom),
                        ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4)));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
